// File: rtl/multicycle_ctrl_if.sv
// Bundle of control-unit signals between the RV32 multicycle controller and its datapath:
// the instruction register, ALU flag, memory-port handshake and all mux selects/strobes.
interface multicycle_ctrl_if;
  logic [31:0] INSTR;
  logic        ZERO;
  // Memory handshake: MEM_READ/MEM_WRITE act as valid and MEM_READY as ready. A transfer
  // completes in the cycle both are high; until then the request and selects stay stable.
  logic        MEM_READY;
  logic [3:0]  ALU_CONTROL;
  logic [1:0]  ALU_SRC_A;
  logic [1:0]  ALU_SRC_B;
  logic        PC_SRC;
  logic [1:0]  RESULT_SEL;
  logic        PC_WRITE;
  logic        IR_WRITE;
  logic        MEM_READ;
  logic        MEM_WRITE;
  logic        REG_WRITE;
  logic        ILLEGAL;
  logic        BUS_ERROR;

  modport master (
    input  INSTR, ZERO, MEM_READY,
    output ALU_CONTROL, ALU_SRC_A, ALU_SRC_B, PC_SRC, RESULT_SEL,
    output PC_WRITE, IR_WRITE, MEM_READ, MEM_WRITE, REG_WRITE, ILLEGAL, BUS_ERROR
  );

  modport slave (
    output INSTR, ZERO, MEM_READY,
    input  ALU_CONTROL, ALU_SRC_A, ALU_SRC_B, PC_SRC, RESULT_SEL,
    input  PC_WRITE, IR_WRITE, MEM_READ, MEM_WRITE, REG_WRITE, ILLEGAL, BUS_ERROR
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// RV32 multicycle control unit: sequences FETCH/DECODE/EXEC/MEM/WB and drives the datapath.
// Optional memory-wait timeout is compiled in with `define MULTICYCLE_CTRL_TIMEOUT_EN.
module multicycle_ctrl #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic               CLK,
  input  logic               RESET,
  multicycle_ctrl_if.master  bus,
  output logic [2:0]         dbg_state,
  output logic [15:0]        dbg_wait
);

  localparam int CW_RAW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int CW     = (CW_RAW < 8) ? 8 : ((CW_RAW > 16) ? 16 : CW_RAW);

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0010;
  localparam logic [3:0] ALU_OR  = 4'b0011;
  localparam logic [3:0] ALU_XOR = 4'b0100;
  localparam logic [3:0] ALU_SLT = 4'b0101;
  localparam logic [3:0] ALU_SLL = 4'b1000;
  localparam logic [3:0] ALU_SRL = 4'b1001;
  localparam logic [3:0] ALU_EQ  = 4'b1010;
  localparam logic [3:0] ALU_LT  = 4'b1011;
  localparam logic [3:0] ALU_GE  = 4'b1100;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_t;

  state_t        state;
  state_t        next_state;
  logic [CW-1:0] wait_cnt;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7_b5;
  logic       unused_instr_bits;

  assign opcode            = bus.INSTR[6:0];
  assign funct3            = bus.INSTR[14:12];
  assign funct7_b5         = bus.INSTR[30];
  assign unused_instr_bits = ^{bus.INSTR[31], bus.INSTR[29:15], bus.INSTR[11:7]};

  logic is_r, is_i, is_lw, is_sw, is_br, is_jal;
  assign is_r   = (opcode == OP_R);
  assign is_i   = (opcode == OP_I);
  assign is_lw  = (opcode == OP_LW);
  assign is_sw  = (opcode == OP_SW);
  assign is_br  = (opcode == OP_BR);
  assign is_jal = (opcode == OP_JAL);

  logic [3:0] alu_fn;
  logic       alu_bad;
  always_comb begin
    alu_fn  = ALU_ADD;
    alu_bad = 1'b0;
    case (funct3)
      3'b000: alu_fn = (is_r && funct7_b5) ? ALU_SUB : ALU_ADD;
      3'b001: alu_fn = ALU_SLL;
      3'b010: alu_fn = ALU_SLT;
      3'b011: alu_bad = 1'b1;
      3'b100: alu_fn = ALU_XOR;
      3'b101: begin
        alu_fn  = ALU_SRL;
        alu_bad = funct7_b5;
      end
      3'b110: alu_fn = ALU_OR;
      default: alu_fn = ALU_AND;
    endcase
  end

  // bne reuses the equality test and inverts the sense of ZERO.
  logic [3:0] br_code;
  logic       br_ok;
  logic       br_taken;
  always_comb begin
    br_code  = ALU_EQ;
    br_ok    = 1'b1;
    br_taken = 1'b0;
    case (funct3)
      3'b000: br_taken = bus.ZERO;
      3'b001: br_taken = !bus.ZERO;
      3'b100: begin
        br_code  = ALU_LT;
        br_taken = bus.ZERO;
      end
      3'b101: begin
        br_code  = ALU_GE;
        br_taken = bus.ZERO;
      end
      default: br_ok = 1'b0;
    endcase
  end

  logic legal;
  assign legal = ((is_r || is_i) && !alu_bad) || is_lw || is_sw || (is_br && br_ok) || is_jal;

  logic waiting;
  logic timeout;
  assign waiting = (state == S_FETCH) || (state == S_MEM);

`ifdef MULTICYCLE_CTRL_TIMEOUT_EN
  // A ready in the limit cycle itself completes normally, so the timeout needs MEM_READY low.
  assign timeout = waiting && !bus.MEM_READY && (wait_cnt == CW'(TIMEOUT_CYCLES - 1));
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    next_state = state;
    case (state)
      S_FETCH: begin
        if (timeout)            next_state = S_FETCH;
        else if (bus.MEM_READY) next_state = S_DECODE;
      end
      S_DECODE: next_state = legal ? S_EXEC : S_FETCH;
      S_EXEC: begin
        if (is_r || is_i)       next_state = S_WB;
        else if (is_lw || is_sw) next_state = S_MEM;
        else                    next_state = S_FETCH;
      end
      S_MEM: begin
        if (timeout)            next_state = S_FETCH;
        else if (bus.MEM_READY) next_state = is_lw ? S_WB : S_FETCH;
      end
      S_WB:    next_state = S_FETCH;
      default: next_state = S_FETCH;
    endcase
  end

  // The wait counter restarts on every state entry, including a timeout re-entry of FETCH.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state    <= S_FETCH;
      wait_cnt <= '0;
    end else begin
      state <= next_state;
      if (timeout || (next_state != state)) begin
        wait_cnt <= '0;
      end else if (waiting && !bus.MEM_READY && (wait_cnt != '1)) begin
        wait_cnt <= wait_cnt + 1'b1;
      end
    end
  end

  logic [3:0] alu_control;
  logic [1:0] src_a, src_b, result_sel;
  logic       pc_src, pc_write, ir_write, mem_read, mem_write, reg_write, illegal, bus_error;

  always_comb begin
    alu_control = ALU_ADD;
    src_a       = 2'b00;
    src_b       = 2'b00;
    result_sel  = 2'b00;
    pc_src      = 1'b0;
    pc_write    = 1'b0;
    ir_write    = 1'b0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    reg_write   = 1'b0;
    illegal     = 1'b0;
    bus_error   = 1'b0;
    if (!RESET) begin
      case (state)
        S_FETCH: begin
          src_b    = 2'b10;
          mem_read = 1'b1;
          ir_write = bus.MEM_READY;
          pc_write = bus.MEM_READY;
        end
        S_DECODE: begin
          src_a   = 2'b01;
          src_b   = 2'b01;
          illegal = !legal;
        end
        S_EXEC: begin
          if (is_r || is_i) begin
            src_a       = 2'b10;
            src_b       = is_i ? 2'b01 : 2'b00;
            alu_control = alu_fn;
          end else if (is_lw || is_sw) begin
            src_a = 2'b10;
            src_b = 2'b01;
          end else if (is_br) begin
            src_a       = 2'b10;
            alu_control = br_code;
            pc_write    = br_taken;
            pc_src      = 1'b1;
          end else if (is_jal) begin
            src_a      = 2'b01;
            src_b      = 2'b10;
            reg_write  = 1'b1;
            result_sel = 2'b10;
            pc_write   = 1'b1;
            pc_src     = 1'b1;
          end
        end
        S_MEM: begin
          mem_write = is_sw;
          mem_read  = !is_sw;
        end
        S_WB: begin
          reg_write  = 1'b1;
          result_sel = is_lw ? 2'b01 : 2'b00;
        end
        default: ;
      endcase
      if (timeout) begin
        pc_write  = 1'b0;
        ir_write  = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        reg_write = 1'b0;
        bus_error = 1'b1;
      end
    end
  end

  assign bus.ALU_CONTROL = alu_control;
  assign bus.ALU_SRC_A   = src_a;
  assign bus.ALU_SRC_B   = src_b;
  assign bus.PC_SRC      = pc_src;
  assign bus.RESULT_SEL  = result_sel;
  assign bus.PC_WRITE    = pc_write;
  assign bus.IR_WRITE    = ir_write;
  assign bus.MEM_READ    = mem_read;
  assign bus.MEM_WRITE   = mem_write;
  assign bus.REG_WRITE   = reg_write;
  assign bus.ILLEGAL     = illegal;
  assign bus.BUS_ERROR   = bus_error;

  assign dbg_state = state;
  assign dbg_wait  = 16'(wait_cnt);

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multicycle control unit for the RV32 processor. It decodes the instruction register and sequences FETCH/DECODE/EXEC/MEM/WB. It drives the ALU's 4-bit operation code and operand selects, and consumes the ALU ZERO flag to resolve branches. It sits between the instruction register, the memory port handshake and the datapath muxes/enables.

## Interface
- TIMEOUT_CYCLES, 255: memory-wait limit in cycles; used only when timeout is compiled in.
- CLK  in  1  rising-edge clock; single clock domain.
- RESET  in  1  synchronous, active-high reset.
- INSTR  in  32  instruction register contents; valid from DECODE onward.
- ZERO  in  1  ALU zero flag, combinational from the current ALU inputs.
- MEM_READY  in  1  memory accepts write / returns read data this cycle.
- ALU_CONTROL  out  4  ALU operation code.
- ALU_SRC_A  out  2  ALU A source: 00 PC, 01 OLDPC, 10 RS1.
- ALU_SRC_B  out  2  ALU B source: 00 RS2, 01 IMM, 10 constant 4.
- PC_SRC  out  1  PC source: 0 ALU result, 1 ALUOUT register.
- RESULT_SEL  out  2  register-file write data: 00 ALUOUT, 01 MEMDATA, 10 ALU result.
- PC_WRITE, IR_WRITE, MEM_READ, MEM_WRITE, REG_WRITE  out  1 each  datapath strobes.
- ILLEGAL  out  1  one-cycle pulse on an unsupported instruction.
- BUS_ERROR  out  1  one-cycle pulse on a memory timeout; constant 0 when timeout is compiled out.

## Operation
- ALU codes:
  - 0000 add, 0001 sub, 0010 and, 0011 or, 0100 xor, 0101 slt, 1000 sll, 1001 srl.
  - 1010 eq-test: ZERO=1 when A==B.
  - 1011 lt-test: ZERO=1 when A<B (signed).
  - 1100 ge-test: ZERO=1 when A>=B.
- Supported opcodes: R 0110011, I-ALU 0010011, LW 0000011, SW 0100011, BRANCH 1100011, JAL 1101111.
- ALU funct3 mapping:
  - 000 add; sub only for R with funct7[5]=1.
  - 001 sll, 010 slt, 100 xor, 101 srl, 110 or, 111 and.
  - 011 and 101 with funct7[5]=1 are illegal.
- FETCH:
  - Drives MEM_READ=1, ALU PC+4 (SRC_A 00, SRC_B 10, add).
  - Holds until MEM_READY=1. In that cycle it asserts IR_WRITE=1, PC_WRITE=1, PC_SRC=0, then moves to DECODE.
- DECODE:
  - Computes OLDPC+IMM (01/01/add); the datapath latches it into ALUOUT.
  - Unsupported opcode/funct: ILLEGAL=1 for this cycle, then FETCH.
  - Otherwise go to EXEC.
- EXEC, by instruction type:
  - R / I-ALU: SRC_A 10, SRC_B 00 (R) or 01 (I), mapped code; then WB.
  - LW / SW: RS1+IMM (10/01/add); then MEM.
  - BRANCH:
    - RS1 vs RS2 (10/00).
    - beq: code 1010, taken if ZERO=1. bne: code 1010, taken if ZERO=0.
    - blt: code 1011, taken if ZERO=1. bge: code 1100, taken if ZERO=1.
    - Other funct3 is decoded as illegal in DECODE.
    - PC_WRITE=taken (Mealy on ZERO), PC_SRC=1; then FETCH.
  - JAL: OLDPC+4 (01/10/add); REG_WRITE=1, RESULT_SEL=10, PC_WRITE=1, PC_SRC=1; then FETCH.
- MEM:
  - LW: MEM_READ=1. SW: MEM_WRITE=1.
  - Holds until MEM_READY. LW then goes to WB; SW goes to FETCH.
- WB:
  - REG_WRITE=1; RESULT_SEL=01 (LW) or 00 (ALU ops); then FETCH.
- Unlisted strobes are 0 in every state. ALU_CONTROL defaults to 0000 and the selects to 00.

## Timing
- RESET high at an edge: state becomes FETCH and the timeout counter clears.
- While RESET is high, all strobes, ILLEGAL and BUS_ERROR are forced to 0; selects and ALU_CONTROL are 0.
- Reset mid-operation (e.g., MEM with MEM_WRITE high): the strobe drops in the same cycle RESET rises. No partial writeback.
- Minimum latency with MEM_READY=1:
  - R/I: 4 cycles. LW: 5. SW: 4.
  - BRANCH / JAL: 3. Illegal: 2.
- Each MEM_READY=0 cycle in FETCH or MEM adds one cycle. Strobes stay asserted and stable during a wait.
- MEM_READY is ignored outside FETCH and MEM.
- All state transitions occur on the CLK rising edge. Outputs are combinational from state, INSTR and ZERO.

## Configuration
- MULTICYCLE_CTRL_TIMEOUT_EN defined:
  - An 8..16-bit wait counter runs in FETCH and MEM and clears on state entry.
  - If MEM_READY stays 0 for TIMEOUT_CYCLES consecutive cycles, BUS_ERROR=1 for one cycle, strobes drop that cycle, and the next state is FETCH.
  - PC is unchanged, so a fetch retries the same address.
  - MEM_READY=1 in the timeout cycle itself takes priority: normal completion, no error.
- Undefined: waits indefinitely; BUS_ERROR constant 0; TIMEOUT_CYCLES unused.

## Test plan
- Reset, then add x3,x1,x2 (0x002081B3), MEM_READY=1 -> cycle 1 IR_WRITE/PC_WRITE; cycle 3 ALU_CONTROL=0000 with SRC 10/00; cycle 4 REG_WRITE=1, RESULT_SEL=00.
- sub (0x402081B3) then srl (0x0020D1B3) -> ALU_CONTROL 0001 then 1001 in EXEC.
- beq with ZERO=1 -> EXEC shows code 1010, PC_WRITE=1, PC_SRC=1. bne (funct3 001) with ZERO=1 -> PC_WRITE=0. bge with ZERO=1 -> code 1100, PC_WRITE=1.
- lw with MEM_READY low 3 cycles in MEM -> MEM_READ held 4 cycles, then WB with RESULT_SEL=01; total 8 cycles.
- Opcode 0x7F -> ILLEGAL pulse in DECODE, FETCH next; RESET asserted during SW in MEM -> MEM_WRITE=0 that cycle, FETCH after release.
- Macro defined, TIMEOUT_CYCLES=4, MEM_READY held 0 in FETCH -> BUS_ERROR on 4th wait cycle, re-enter FETCH, no PC_WRITE.
